// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake round-robin arbiter: FSM encodings and
// the requester-id width helper.
package handshake_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // At least one bit so a degenerate N still yields a legal vector width.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/handshake_rr_arbiter_rr_pick.sv
// Combinational rotating priority search: first set request at or after ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Walk the requesters in rotated order; the first hit wins.
    always_comb begin
        int c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c     = (int'(ptr) + k >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
            idx   = (!found && req[c]) ? IW'(c) : idx;
            found = found | req[c];
        end
    end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter with burst lock feeding a one-deep registered
// valid/ready output stage shared by N requesters.
module handshake_rr_arbiter
    import handshake_pkg::*;
#(
    parameter int  N  = 4,
    parameter int  DW = 32,
    localparam int IW = id_width(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N*DW-1:0] req_data,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    output logic            slave_valid,
    output logic [DW-1:0]   slave_data,
    output logic            slave_last,
    output logic [IW-1:0]   slave_id,
    input  logic            slave_ready
);

    arb_state_e    state_r, state_nxt_s;
    logic [IW-1:0] lock_id_r, lock_id_nxt_s;
    logic [IW-1:0] rr_ptr_r, rr_ptr_nxt_s;
    logic          valid_r, valid_nxt_s;
    logic [DW-1:0] data_r, data_nxt_s;
    logic          last_r, last_nxt_s;
    logic [IW-1:0] id_r, id_nxt_s;

    logic          pick_found_s;
    logic [IW-1:0] pick_idx_s;
    logic [IW-1:0] cand_s;
    logic          cand_ok_s;
    logic          cand_last_s;
    logic [DW-1:0] cand_data_s;
    logic          accept_s;
    logic          xfer_s;
    logic [N-1:0]  req_ready_s;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Candidate: rotating search when free, the lock owner only when mid-burst.
    always_comb begin
        cand_s    = pick_idx_s;
        cand_ok_s = pick_found_s;
        case (state_r)
            ARB_IDLE: begin
                cand_s    = pick_idx_s;
                cand_ok_s = pick_found_s;
            end
            ARB_LOCKED: begin
                cand_s    = lock_id_r;
                cand_ok_s = req_valid[lock_id_r];
            end
            default: begin
                cand_s    = '0;
                cand_ok_s = 1'b0;
            end
        endcase
    end

    assign accept_s    = slave_ready | ~valid_r;
    assign xfer_s      = accept_s & cand_ok_s & ~rst;
    assign cand_last_s = req_last[cand_s];
    assign cand_data_s = req_data[cand_s*DW +: DW];

    // Ready goes only to the candidate, and only when the slot can take a beat.
    always_comb begin
        req_ready_s = '0;
        if (xfer_s) begin
            req_ready_s[cand_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign req_ready = req_ready_s;

    // Next-state: load on transfer, drain on consumption, lock until last.
    always_comb begin
        state_nxt_s   = state_r;
        lock_id_nxt_s = lock_id_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        valid_nxt_s   = valid_r;
        data_nxt_s    = data_r;
        last_nxt_s    = last_r;
        id_nxt_s      = id_r;
        if (xfer_s) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = cand_data_s;
            last_nxt_s  = cand_last_s;
            id_nxt_s    = cand_s;
            if (cand_last_s) begin
                state_nxt_s  = ARB_IDLE;
                rr_ptr_nxt_s = (cand_s == IW'(N - 1)) ? '0 : (cand_s + IW'(1));
            end else begin
                state_nxt_s   = ARB_LOCKED;
                lock_id_nxt_s = cand_s;
            end
        end else if (valid_r & slave_ready) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // State, pointer, lock and output register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ARB_IDLE;
            lock_id_r <= '0;
            rr_ptr_r  <= '0;
            valid_r   <= 1'b0;
            data_r    <= '0;
            last_r    <= 1'b0;
            id_r      <= '0;
        end else begin
            state_r   <= state_nxt_s;
            lock_id_r <= lock_id_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
            valid_r   <= valid_nxt_s;
            data_r    <= data_nxt_s;
            last_r    <= last_nxt_s;
            id_r      <= id_nxt_s;
        end
    end

    assign slave_valid = valid_r;
    assign slave_data  = data_r;
    assign slave_last  = last_r;
    assign slave_id    = id_r;

endmodule

// File: doc/handshake_rr_arbiter.md
# handshake_rr_arbiter

Round-robin arbiter that shares one registered valid/ready output stage among N requesters. Each requester presents a valid/data/last stream. Grants are held for a whole burst, which runs from the first beat up to and including the beat with `last`. The winner's beats pass through a one-deep output register with the same valid-patting acceptance rule as the team's pipe stages. The block sits in front of any single-consumer datapath that several producers must share.

## Interface
Parameters:
- `N`, 4, number of requesters; N ≥ 2, need not be a power of two.
- `DW`, 32, data width.
- `IW`, $clog2(N), requester-id width; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  N  per-requester valid.
- `req_data`  in  N*DW  requester i occupies bits [i*DW +: DW].
- `req_last`  in  N  marks the final beat of a burst.
- `req_ready`  out  N  per-requester ready; one-hot or zero.
- `slave_valid`  out  1  output register holds a beat.
- `slave_data`  out  DW  registered beat data.
- `slave_last`  out  1  registered last flag.
- `slave_id`  out  IW  index of the requester that sent the beat.
- `slave_ready`  in  1  downstream ready.

## Operation
- Output slot can accept when `slave_ready | ~slave_valid` (`accept`).
- State machine, two states:
  - IDLE: no burst lock is held.
  - LOCKED: `lock_id` is owned mid-burst.
- Candidate selection:
  - IDLE: the first i with `req_valid[i]`, searching `rr_ptr`, `rr_ptr+1`, … mod N.
  - LOCKED: only `lock_id`.
- `req_ready[g] = accept & req_valid[g]` for candidate g; all other bits are 0. `req_ready` is zero when there is no candidate.
- On a transfer (`req_valid[g] & req_ready[g]`):
  - Load `slave_data`, `slave_last` and `slave_id=g`.
  - Set `slave_valid` to 1.
- If the transferred beat has `last=0`:
  - IDLE→LOCKED, `lock_id=g`.
  - LOCKED stays LOCKED.
- If the transferred beat has `last=1`:
  - The state becomes IDLE.
  - `rr_ptr = (g==N-1) ? 0 : g+1`.
  - Single-beat bursts taken in IDLE follow the same rule.
- When there is no transfer and `slave_valid & slave_ready`, `slave_valid` is cleared.
- A LOCKED owner that drops valid stalls the block; other requesters are not served until its `last` beat transfers.
- `rr_ptr` changes only on a `last` transfer.

## Timing
- Reset (`rst`=1 at an edge) clears:
  - `slave_valid`, `slave_data`, `slave_last`, `slave_id` to 0.
  - `rr_ptr` to 0.
  - `lock_id` to 0.
  - The state to IDLE.
- Reset mid-burst discards the lock and any held beat.
- While `rst` is asserted, `req_ready` = 0.
- Latency: 1 cycle from input transfer to `slave_valid`.
- Throughput: 1 beat per cycle when `slave_ready` is held high.
- Simultaneous drain and fill: the new beat overwrites and `slave_valid` stays 1 with no bubble.
- Combinational path `slave_ready` → `req_ready` is intended; there is no path from `req_data` to outputs.
- Wrap-around: the search order after requester N-1 restarts at 0.
- With non-power-of-two N, `rr_ptr` never takes values ≥ N.

## Structure
- Shared package `handshake_pkg`:
  - State encodings `ARB_IDLE=1'b0`, `ARB_LOCKED=1'b1`.
  - Id-width helper function.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: N-bit request vector, `rr_ptr`.
  - Outputs: `found` and index.
- Pointer, lock and output register logic stay in the top level.

## Test plan
- Reset/idle: assert `rst` for 2 cycles with all `req_valid`=1 → `req_ready`=0 throughout; all outputs 0 after release.
- Fair single beats: N=4, all requesters valid, `last`=1, `slave_ready`=1 → `slave_id` sequence 0,1,2,3,0, one beat per cycle, first beat 1 cycle after the first grant.
- Burst lock: requester 2 sends 3 beats (`last` on the third) while requester 0 is valid throughout → ids 2,2,2 then 0; `rr_ptr`=3 after the burst.
- Owner gap: requester 1 drops valid for 2 cycles mid-burst while requester 3 is valid → no output beats during the gap; `req_ready[3]`=0 until requester 1's `last` transfers.
- Backpressure: `slave_ready`=0 with a beat held → `slave_data`/`slave_id` stable and `req_ready`=0. Release `slave_ready` while a new requester is valid → transfer in the same cycle; `slave_valid` stays 1.
- Non-power-of-two/reset mid-burst:
  - N=3, all valid, single beats → ids 0,1,2,0.
  - Assert `rst` during a burst from requester 1 → next grant goes to requester 0.
